execute_stage_md: RTL and testbench

//  Next-generation EX stage of the 5-stage MIPS pipeline. It holds the ID/EX register with stall/flush control and operand

---
 rtl/execute_stage_md.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_execute_stage_md.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_md.sv
// -----------------------------------------------------------------------------
// execute_stage_md -- EX stage of a 5-stage MIPS pipeline
//
// Holds the ID/EX pipeline register (stall / flush / operand forwarding), the
// ALU datapath, the branch-target adder and a multi-cycle MULT/MULTU/DIV/DIVU
// unit with its HI/LO result registers.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   stall_e_i, flush_e_i        hazard unit: hold / bubble the ID/EX register
//   rd1_d, rd2_d                register-file operands from decode
//   fwd_{a,b}_en_i, fwd_{a,b}_i forwarded operands replacing rd1_d / rd2_d
//   shamt_d, rt_d, rd_d         shift amount and destination candidates
//   imm_d, pc_plus_4d           sign-extended immediate, PC+4 of decode instr
//   *_d control                 decode control bits, alu_control_d, alu_src_d
//   md_op_d                     0 none,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO
//   alu_out_e .. pc_branch_e    EX results and control towards MEM
//   md_busy_o                   multiply/divide unit iterating
//   md_stall_o                  EX instruction waits on the unit
//
// ALU encoding (alu_control):
//   0 AND  1 OR   2 ADD  3 XOR  4 NOR  5 SLTU  6 SUB  7 SLT
//   8 SLL (src2 << src1)   9 SRL   10 SRA   11 LUI (src2 << XLEN/2)
//   12..15 produce 0
// -----------------------------------------------------------------------------

module execute_alu #(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] sh;
  assign sh = src_a[SW-1:0];

  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path driven,
    // so no latch is inferred for unlisted encodings.
    result = '0;
    case (alu_control)
      4'd0:  result = src_a & src_b;
      4'd1:  result = src_a | src_b;
      4'd2:  result = src_a + src_b;
      4'd3:  result = src_a ^ src_b;
      4'd4:  result = ~(src_a | src_b);
      4'd5:  result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      4'd6:  result = src_a - src_b;
      4'd7:  result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'd8:  result = src_b << sh;
      4'd9:  result = src_b >> sh;
      4'd10: result = $unsigned($signed(src_b) >>> sh);
      4'd11: result = src_b << (XLEN / 2);
      default: result = '0;
    endcase
  end

endmodule

module execute_stage_md #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_e_i,
  input  logic            flush_e_i,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic            fwd_a_en_i,
  input  logic            fwd_b_en_i,
  input  logic [XLEN-1:0] fwd_a_i,
  input  logic [XLEN-1:0] fwd_b_i,
  input  logic [4:0]      shamt_d,
  input  logic [4:0]      rt_d,
  input  logic [4:0]      rd_d,
  input  logic [XLEN-1:0] imm_d,
  input  logic [XLEN-1:0] pc_plus_4d,
  input  logic            reg_write_d,
  input  logic            mem_to_reg_d,
  input  logic            mem_write_d,
  input  logic            branch_d,
  input  logic            reg_dst_d,
  input  logic [3:0]      alu_control_d,
  input  logic [1:0]      alu_src_d,
  input  logic [2:0]      md_op_d,
  output logic [XLEN-1:0] alu_out_e,
  output logic [XLEN-1:0] write_data_e,
  output logic [4:0]      write_reg_e,
  output logic            reg_write_e,
  output logic            mem_to_reg_e,
  output logic            mem_write_e,
  output logic            branch_e,
  output logic            zero_e,
  output logic [XLEN-1:0] pc_branch_e,
  output logic            md_busy_o,
  output logic            md_stall_o
);

  // XLEN restoring iterations plus one sign-fixup cycle.
  localparam int DIV_CYCLES = XLEN + 1;
  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MFHI  = 3'd5,
    MD_MFLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} md_state_t;

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_branch;
    logic [4:0]      shamt;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_to_reg;
    logic            mem_write;
    logic            branch;
    logic            reg_dst;
    logic [3:0]      alu_control;
    logic [1:0]      alu_src;
    md_op_t          md_op;
  } id_ex_t;

  id_ex_t ex, ex_next;

  // ---------------------------------------------------------------------------
  // ID/EX register
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_next             = '0;
    ex_next.rd1         = fwd_a_en_i ? fwd_a_i : rd1_d;
    ex_next.rd2         = fwd_b_en_i ? fwd_b_i : rd2_d;
    ex_next.imm         = imm_d;
    ex_next.pc_branch   = pc_plus_4d + (imm_d << 2);
    ex_next.shamt       = shamt_d;
    ex_next.rt          = rt_d;
    ex_next.rd          = rd_d;
    ex_next.reg_write   = reg_write_d;
    ex_next.mem_to_reg  = mem_to_reg_d;
    ex_next.mem_write   = mem_write_d;
    ex_next.branch      = branch_d;
    ex_next.reg_dst     = reg_dst_d;
    ex_next.alu_control = alu_control_d;
    ex_next.alu_src     = alu_src_d;
    ex_next.md_op       = md_op_t'(md_op_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      ex <= '0;
    end else if (flush_e_i) begin
      ex <= '0;
    end else if (!(stall_e_i || md_stall_o)) begin
      ex <= ex_next;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU datapath
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] src_a, src_b, alu_result;

  assign src_a = ex.alu_src[0] ? XLEN'(ex.shamt) : ex.rd1;
  assign src_b = ex.alu_src[1] ? ex.imm : ex.rd2;

  execute_alu #(.XLEN(XLEN)) u_alu (
    .alu_control (ex.alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .result      (alu_result)
  );

  // ---------------------------------------------------------------------------
  // Multiply / divide unit
  // ---------------------------------------------------------------------------
  md_state_t       md_state;
  logic [CW-1:0]   md_cnt;
  logic            md_busy;
  logic            md_signed;
  logic [XLEN-1:0] md_a, md_b;
  logic [XLEN-1:0] div_rem, div_quo;
  logic [XLEN-1:0] hi, lo;

  logic            md_uses, md_start, start_signed, start_is_mul;
  logic [XLEN-1:0] start_mag_a;

  assign md_uses      = (ex.md_op != MD_NONE) && (ex.md_op != MD_RSVD);
  assign md_start     = (ex.md_op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU})
                        && (md_state == ST_IDLE) && !stall_e_i;
  assign start_signed = (ex.md_op == MD_MULT) || (ex.md_op == MD_DIV);
  assign start_is_mul = (ex.md_op == MD_MULT) || (ex.md_op == MD_MULTU);
  assign start_mag_a  = (start_signed && ex.rd1[XLEN-1]) ? -ex.rd1 : ex.rd1;

  // Sign-extending both operands to 2*XLEN makes one unsigned product serve
  // MULT and MULTU; the low 2*XLEN bits are the exact result either way.
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
  assign mul_a_ext = {{XLEN{md_signed & md_a[XLEN-1]}}, md_a};
  assign mul_b_ext = {{XLEN{md_signed & md_b[XLEN-1]}}, md_b};
  assign mul_prod  = mul_a_ext * mul_b_ext;

  // Restoring division on magnitudes: shift one dividend bit into the
  // partial remainder, keep the difference when it does not go negative.
  logic [XLEN-1:0] den_mag;
  logic [XLEN:0]   div_shift, div_diff;
  assign den_mag   = (md_signed && md_b[XLEN-1]) ? -md_b : md_b;
  assign div_shift = {div_rem, div_quo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, den_mag};

  logic [XLEN-1:0] div_hi, div_lo;
  always_comb begin
    div_lo = (md_signed && (md_a[XLEN-1] ^ md_b[XLEN-1])) ? -div_quo : div_quo;
    div_hi = (md_signed && md_a[XLEN-1]) ? -div_rem : div_rem;
    if (md_b == '0) begin
      div_lo = '1;
      div_hi = md_a;
    end else if (md_signed && (md_a == XMIN) && (md_b == '1)) begin
      div_lo = XMIN;
      div_hi = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: HI/LO are architecturally visible through MFHI/MFLO and must read
    // zero after reset, so they take the async reset like every other register.
    if (!rst_n) begin
      md_state  <= ST_IDLE;
      md_cnt    <= '0;
      md_busy   <= 1'b0;
      md_signed <= 1'b0;
      md_a      <= '0;
      md_b      <= '0;
      div_rem   <= '0;
      div_quo   <= '0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (md_state)
        ST_IDLE: begin
          if (md_start) begin
            md_a      <= ex.rd1;
            md_b      <= ex.rd2;
            md_signed <= start_signed;
            md_busy   <= 1'b1;
            div_rem   <= '0;
            div_quo   <= start_mag_a;
            if (start_is_mul) begin
              md_state <= ST_MUL;
              md_cnt   <= CW'(MUL_CYCLES - 1);
            end else begin
              md_state <= ST_DIV;
              md_cnt   <= CW'(DIV_CYCLES - 1);
            end
          end
        end
        ST_MUL: begin
          if (md_cnt == '0) begin
            hi       <= mul_prod[2*XLEN-1:XLEN];
            lo       <= mul_prod[XLEN-1:0];
            md_busy  <= 1'b0;
            md_state <= ST_IDLE;
          end else begin
            md_cnt <= md_cnt - CW'(1);
          end
        end
        ST_DIV: begin
          if (md_cnt == '0) begin
            // Sign-fixup cycle.
            hi       <= div_hi;
            lo       <= div_lo;
            md_busy  <= 1'b0;
            md_state <= ST_IDLE;
          end else begin
            if (!div_diff[XLEN]) begin
              div_rem <= div_diff[XLEN-1:0];
              div_quo <= {div_quo[XLEN-2:0], 1'b1};
            end else begin
              div_rem <= div_shift[XLEN-1:0];
              div_quo <= {div_quo[XLEN-2:0], 1'b0};
            end
            md_cnt <= md_cnt - CW'(1);
          end
        end
        default: md_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    case (ex.md_op)
      MD_MFHI: alu_out_e = hi;
      MD_MFLO: alu_out_e = lo;
      default: alu_out_e = alu_result;
    endcase
  end

  assign md_busy_o    = md_busy;
  assign md_stall_o   = md_busy && md_uses;
  assign zero_e       = (alu_out_e == '0);
  assign write_data_e = ex.rd2;
  assign write_reg_e  = ex.reg_dst ? ex.rd : ex.rt;
  assign pc_branch_e  = ex.pc_branch;

  // A stalled EX instruction must not reach MEM; send a bubble instead.
  assign reg_write_e  = ex.reg_write  && !md_stall_o;
  assign mem_to_reg_e = ex.mem_to_reg && !md_stall_o;
  assign mem_write_e  = ex.mem_write  && !md_stall_o;
  assign branch_e     = ex.branch     && !md_stall_o;

endmodule

// File: tb/tb_execute_stage_md.sv
module tb_execute_stage_md;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_e_i, flush_e_i;
  logic [31:0] rd1_d, rd2_d, fwd_a_i, fwd_b_i, imm_d, pc_plus_4d;
  logic        fwd_a_en_i, fwd_b_en_i;
  logic [4:0]  shamt_d, rt_d, rd_d;
  logic        reg_write_d, mem_to_reg_d, mem_write_d, branch_d, reg_dst_d;
  logic [3:0]  alu_control_d;
  logic [1:0]  alu_src_d;
  logic [2:0]  md_op_d;
  logic [31:0] alu_out_e, write_data_e, pc_branch_e;
  logic [4:0]  write_reg_e;
  logic        reg_write_e, mem_to_reg_e, mem_write_e, branch_e, zero_e;
  logic        md_busy_o, md_stall_o;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  execute_stage_md dut (
    .clk(clk), .rst_n(rst_n), .stall_e_i(stall_e_i), .flush_e_i(flush_e_i),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .fwd_a_en_i(fwd_a_en_i), .fwd_b_en_i(fwd_b_en_i),
    .fwd_a_i(fwd_a_i), .fwd_b_i(fwd_b_i), .shamt_d(shamt_d), .rt_d(rt_d), .rd_d(rd_d),
    .imm_d(imm_d), .pc_plus_4d(pc_plus_4d), .reg_write_d(reg_write_d),
    .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d), .branch_d(branch_d),
    .reg_dst_d(reg_dst_d), .alu_control_d(alu_control_d), .alu_src_d(alu_src_d),
    .md_op_d(md_op_d), .alu_out_e(alu_out_e), .write_data_e(write_data_e),
    .write_reg_e(write_reg_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
    .mem_write_e(mem_write_e), .branch_e(branch_e), .zero_e(zero_e),
    .pc_branch_e(pc_branch_e), .md_busy_o(md_busy_o), .md_stall_o(md_stall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: instruction in EX, HI/LO, remaining busy cycles and the
  // result the unit will deliver when they run out.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] a, b, imm, pcb;
    logic [4:0]  shamt, rt, rd;
    logic        rw, m2r, mw, br, dst;
    logic [3:0]  ctl;
    logic [1:0]  src;
    logic [2:0]  op;
  } ex_t;

  ex_t         m_ex;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_left;

  function automatic ex_t dec_in();
    ex_t e;
    e.a     = fwd_a_en_i ? fwd_a_i : rd1_d;
    e.b     = fwd_b_en_i ? fwd_b_i : rd2_d;
    e.imm   = imm_d;
    e.pcb   = pc_plus_4d + imm_d * 4;
    e.shamt = shamt_d;
    e.rt    = rt_d;
    e.rd    = rd_d;
    e.rw    = reg_write_d;
    e.m2r   = mem_to_reg_d;
    e.mw    = mem_write_d;
    e.br    = branch_d;
    e.dst   = reg_dst_d;
    e.ctl   = alu_control_d;
    e.src   = alu_src_d;
    e.op    = md_op_d;
    return e;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    int sb;
    sb = int'(b);
    case (ctl)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return ~(a | b);
      4'd5:  return (a < b) ? 32'd1 : 32'd0;
      4'd6:  return a - b;
      4'd7:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd8:  return b << a[4:0];
      4'd9:  return b >> a[4:0];
      4'd10: return 32'(sb >>> a[4:0]);
      4'd11: return b * 32'h10000;
      default: return 32'd0;
    endcase
  endfunction

  // Returns {HI, LO}.
  function automatic logic [63:0] md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int q, r;
    case (op)
      3'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
      end
      3'd2: return {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {32'(r), 32'(q)};
      end
      3'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic exp_busy();
    return m_left > 0;
  endfunction

  function automatic logic exp_stall();
    return (m_left > 0) && (m_ex.op >= 3'd1) && (m_ex.op <= 3'd6);
  endfunction

  function automatic logic [31:0] exp_alu();
    logic [31:0] s1, s2;
    if (m_ex.op == 3'd5) return m_hi;
    if (m_ex.op == 3'd6) return m_lo;
    s1 = m_ex.src[0] ? {27'd0, m_ex.shamt} : m_ex.a;
    s2 = m_ex.src[1] ? m_ex.imm : m_ex.b;
    return ref_alu(m_ex.ctl, s1, s2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex   <= '0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_res  <= '0;
      m_left <= 0;
    end else begin
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) {m_hi, m_lo} <= m_res;
      end else if (m_ex.op >= 3'd1 && m_ex.op <= 3'd4 && !stall_e_i) begin
        m_left <= (m_ex.op <= 3'd2) ? 4 : 33;
        m_res  <= md_ref(m_ex.op, m_ex.a, m_ex.b);
      end
      if (flush_e_i) m_ex <= '0;
      else if (!(stall_e_i || exp_stall())) m_ex <= dec_in();
    end
  end

  // Compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("md_busy_o", 32'(md_busy_o), 32'(exp_busy()));
      check("md_stall_o", 32'(md_stall_o), 32'(exp_stall()));
      check("reg_write_e", 32'(reg_write_e), 32'(m_ex.rw && !exp_stall()));
      check("mem_to_reg_e", 32'(mem_to_reg_e), 32'(m_ex.m2r && !exp_stall()));
      check("mem_write_e", 32'(mem_write_e), 32'(m_ex.mw && !exp_stall()));
      check("branch_e", 32'(branch_e), 32'(m_ex.br && !exp_stall()));
      if (!exp_stall()) begin
        check("alu_out_e", alu_out_e, exp_alu());
        check("zero_e", 32'(zero_e), 32'(exp_alu() == 32'd0));
        check("write_data_e", write_data_e, m_ex.b);
        check("write_reg_e", 32'(write_reg_e), 32'(m_ex.dst ? m_ex.rd : m_ex.rt));
        check("pc_branch_e", pc_branch_e, m_ex.pcb);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_dec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ctl, input logic rw, input logic [4:0] rd);
    stall_e_i = 0; flush_e_i = 0;
    rd1_d = a; rd2_d = b;
    fwd_a_en_i = 0; fwd_b_en_i = 0; fwd_a_i = 0; fwd_b_i = 0;
    shamt_d = 0; rt_d = 0; rd_d = rd; imm_d = 0; pc_plus_4d = 0;
    reg_write_d = rw; mem_to_reg_d = 0; mem_write_d = 0; branch_d = 0; reg_dst_d = 1;
    alu_control_d = ctl; alu_src_d = 0; md_op_d = op;
  endtask

  // Issue an MD op followed by MFHI and MFLO; check busy length, the stall
  // bubble and the delivered HI/LO.
  task automatic md_directed(input string name, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input int exp_cycles,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    @(negedge clk) set_dec(op, a, b, 4'd0, 1'b0, 5'd0);
    @(negedge clk) set_dec(3'd5, 0, 0, 4'd0, 1'b1, 5'd2);
    @(negedge clk) set_dec(3'd6, 0, 0, 4'd0, 1'b1, 5'd3);
    n = 0;
    while (md_busy_o === 1'b1 && n < 100) begin
      check({name, " stall"}, 32'(md_stall_o), 32'd1);
      check({name, " bubble"}, 32'(reg_write_e), 32'd0);
      n++;
      @(negedge clk);
    end
    check({name, " busy cycles"}, 32'(n), 32'(exp_cycles));
    check({name, " HI"}, alu_out_e, exp_hi);
    check({name, " mfhi reg_write"}, 32'(reg_write_e), 32'd1);
    @(negedge clk);
    check({name, " LO"}, alu_out_e, exp_lo);
    set_dec(0, 0, 0, 4'd0, 1'b0, 5'd0);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int r;
    set_dec(0, 0, 0, 4'd0, 1'b0, 5'd0);
    #12;
    check("reset alu_out_e", alu_out_e, 32'd0);
    check("reset zero_e", 32'(zero_e), 32'd1);
    check("reset md_busy_o", 32'(md_busy_o), 32'd0);
    check("reset write_reg_e", 32'(write_reg_e), 32'd0);
    check("reset pc_branch_e", pc_branch_e, 32'd0);
    check("reset reg_write_e", 32'(reg_write_e), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    cmp_en = 1'b1;

    // ALU path, flush+stall, forwarding, stall hold, shamt source.
    @(negedge clk) set_dec(0, 1, 2, 4'd2, 1'b1, 5'd7);
    @(negedge clk);
    check("add alu_out_e", alu_out_e, 32'd3);
    check("add write_reg_e", 32'(write_reg_e), 32'd7);
    set_dec(0, 1, 2, 4'd2, 1'b1, 5'd7);
    flush_e_i = 1; stall_e_i = 1;
    @(negedge clk);
    check("flush reg_write_e", 32'(reg_write_e), 32'd0);
    check("flush alu_out_e", alu_out_e, 32'd0);
    set_dec(0, 100, 3, 4'd2, 1'b1, 5'd9);
    fwd_a_en_i = 1; fwd_a_i = 5;
    @(negedge clk);
    check("fwd add alu_out_e", alu_out_e, 32'd8);
    check("fwd add reg_write_e", 32'(reg_write_e), 32'd1);
    set_dec(0, 50, 50, 4'd2, 1'b1, 5'd9);
    stall_e_i = 1;
    @(negedge clk);
    check("stall hold alu_out_e", alu_out_e, 32'd8);
    set_dec(0, 0, 3, 4'd8, 1'b1, 5'd4);
    shamt_d = 4; alu_src_d = 2'b01; pc_plus_4d = 32'h100; imm_d = 4;
    @(negedge clk);
    check("sll alu_out_e", alu_out_e, 32'h30);
    check("pc_branch_e", pc_branch_e, 32'h110);
    set_dec(0, 5, 5, 4'd6, 1'b1, 5'd1);
    @(negedge clk);
    check("sub zero_e", 32'(zero_e), 32'd1);
    set_dec(0, 0, 0, 4'd0, 1'b0, 5'd0);

    md_directed("mult", 3'd1, 32'hFFFF_FFFF, 32'd2, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    md_directed("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 4, 32'h0000_0001, 32'hFFFF_FFFE);

    // Reset in the middle of a divide.
    @(negedge clk) set_dec(3'd3, 32'd100, 32'd7, 4'd0, 1'b0, 5'd0);
    @(negedge clk) set_dec(0, 0, 0, 4'd0, 1'b0, 5'd0);
    repeat (10) @(negedge clk);
    check("div running", 32'(md_busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst md_busy_o", 32'(md_busy_o), 32'd0);
    check("rst alu_out_e", alu_out_e, 32'd0);
    check("rst zero_e", 32'(zero_e), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(negedge clk);
    set_dec(3'd5, 0, 0, 4'd0, 1'b1, 5'd2);
    @(negedge clk) set_dec(3'd6, 0, 0, 4'd0, 1'b1, 5'd3);
    check("post-reset HI", alu_out_e, 32'd0);
    @(negedge clk) set_dec(0, 0, 0, 4'd0, 1'b0, 5'd0);
    check("post-reset LO", alu_out_e, 32'd0);

    md_directed("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md_directed("divu0", 3'd4, 32'd7, 32'd0, 33, 32'd7, 32'hFFFF_FFFF);
    md_directed("divmin", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);

    // Randomised traffic checked by the compare process.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      stall_e_i     = ($urandom_range(0, 7) == 0);
      flush_e_i     = ($urandom_range(0, 15) == 0);
      rd1_d         = rand_word();
      rd2_d         = rand_word();
      fwd_a_en_i    = ($urandom_range(0, 3) == 0);
      fwd_b_en_i    = ($urandom_range(0, 3) == 0);
      fwd_a_i       = rand_word();
      fwd_b_i       = rand_word();
      shamt_d       = 5'($urandom);
      rt_d          = 5'($urandom);
      rd_d          = 5'($urandom);
      imm_d         = rand_word();
      pc_plus_4d    = $urandom;
      reg_write_d   = 1'($urandom);
      mem_to_reg_d  = 1'($urandom);
      mem_write_d   = 1'($urandom);
      branch_d      = 1'($urandom);
      reg_dst_d     = 1'($urandom);
      alu_control_d = 4'($urandom);
      alu_src_d     = 2'($urandom);
      r = $urandom_range(0, 19);
      md_op_d       = (r < 12) ? 3'd0 : 3'(r - 12);
      if (i % 997 == 500) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk) set_dec(0, 0, 0, 4'd0, 1'b0, 5'd0);
    repeat (40) @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
